// File: rtl/pipeline_pkg.sv
// Shared types for the two-entry pipeline barrier.
//   state_t   : barrier fill state, encoded so that the value equals the
//               number of held entries
//   OCC_W     : width of the occupancy output
package pipeline_pkg;

   localparam int OCC_W = 2;

   typedef enum logic [OCC_W-1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for barrier statistics.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset, clears the count
//   inc  : count one event this cycle
//   cnt  : current count, sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_barrier.sv
// Two-entry (main + skid) valid/ready pipeline register with stall and flush.
// up_ready depends only on registered state, stall and flush, never on
// dn_ready, so the barrier breaks the ready timing path between stages.
// Optional statistics counters are built when PIPELINE_BARRIER_STATS_EN is
// defined.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   up_valid/up_ready   : upstream handshake, up_data payload
//   dn_valid/dn_ready   : downstream handshake, dn_data payload (from main)
//   stall               : freezes all transfers and contents
//   flush               : discards all contents at the next edge
//   occupancy           : number of held entries (0..2)
//   stall_cnt/flush_cnt/xfer_cnt : statistics (PIPELINE_BARRIER_STATS_EN)
//
// state | meaning
// EMPTY | nothing held
// ONE   | main holds the head word
// FULL  | main holds the head word, skid holds the next one
module pipeline_barrier
   import pipeline_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              up_valid,
   output logic              up_ready,
   input  logic [DATA_W-1:0] up_data,
   output logic              dn_valid,
   input  logic              dn_ready,
   output logic [DATA_W-1:0] dn_data,
   input  logic              stall,
   input  logic              flush,
   output logic [OCC_W-1:0]  occupancy
`ifdef PIPELINE_BARRIER_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic [CNT_W-1:0]  xfer_cnt
`endif
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   // Low in reset and for the cycle before the first edge after release,
   // so up_ready cannot assert while the barrier is held in reset.
   logic              alive_q, alive_d;
   logic              accept;
   logic              take;

   assign up_ready  = alive_q && (state_q != FULL) && !stall && !flush;
   assign dn_valid  = (state_q != EMPTY) && !stall && !flush;
   assign dn_data   = main_q;
   assign occupancy = OCC_W'(state_q);
   assign accept    = up_valid && up_ready;
   assign take      = dn_valid && dn_ready;
   assign alive_d   = 1'b1;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else if (!stall) begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_d  = up_data;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (accept && take) begin
                  main_d = up_data;
               end else if (accept) begin
                  skid_d  = up_data;
                  state_d = FULL;
               end else if (take) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (take) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         alive_q <= alive_d;
      end
   end

`ifdef PIPELINE_BARRIER_STATS_EN
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall && (state_q != EMPTY)),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (flush),
      .cnt (flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_xfer_cnt (
      .clk (clk),
      .rst (rst),
      .inc (take),
      .cnt (xfer_cnt)
   );
`endif

endmodule

// File: tb/tb_pipeline_barrier.sv
// Directed bench for pipeline_barrier. Inputs change 2 time units after the
// rising edge; outputs are sampled 1 unit later, well away from the edge.
module tb_pipeline_barrier;
   import pipeline_pkg::*;

   localparam int DATA_W = 64;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              up_valid = 1'b0;
   logic              up_ready;
   logic [DATA_W-1:0] up_data = '0;
   logic              dn_valid;
   logic              dn_ready = 1'b0;
   logic [DATA_W-1:0] dn_data;
   logic              stall = 1'b0;
   logic              flush = 1'b0;
   logic [OCC_W-1:0]  occupancy;
`ifdef PIPELINE_BARRIER_STATS_EN
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   logic [CNT_W-1:0]  xfer_cnt;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pipeline_barrier #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .up_valid  (up_valid),
      .up_ready  (up_ready),
      .up_data   (up_data),
      .dn_valid  (dn_valid),
      .dn_ready  (dn_ready),
      .dn_data   (dn_data),
      .stall     (stall),
      .flush     (flush),
      .occupancy (occupancy)
`ifdef PIPELINE_BARRIER_STATS_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt),
      .xfer_cnt  (xfer_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance to 2 units after the next rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // sample point inside the current cycle
   task automatic settle();
      #1;
   endtask

   initial begin
      int takes;
      int order_err;
      int occ_err;
      int dv_err;
      logic [63:0] next_exp;

      // reset state
      #1 rst = 1'b0;
      settle();
      chk("rst_occ",      64'(occupancy), 64'd0);
      chk("rst_dn_valid", 64'(dn_valid),  64'd0);
      chk("rst_up_ready", 64'(up_ready),  64'd0);
      chk("rst_dn_data",  dn_data,        64'd0);
      tick();
      tick();
      @(negedge clk);
      rst = 1'b1;
      settle();
      chk("rel_up_ready_before_edge", 64'(up_ready), 64'd0);
      tick();
      chk("rel_up_ready_after_edge", 64'(up_ready), 64'd1);

      // single word
      up_valid = 1'b1; up_data = 64'hA5; dn_ready = 1'b1;
      settle();
      chk("single_up_ready", 64'(up_ready), 64'd1);
      chk("single_dn_valid_same_cycle", 64'(dn_valid), 64'd0);
      tick();
      up_valid = 1'b0;
      settle();
      chk("single_dn_valid", 64'(dn_valid),  64'd1);
      chk("single_dn_data",  dn_data,        64'hA5);
      chk("single_occ",      64'(occupancy), 64'd1);
      tick();
      settle();
      chk("single_occ_after", 64'(occupancy), 64'd0);
      chk("single_dn_valid_after", 64'(dn_valid), 64'd0);

      // backpressure
      tick();
      dn_ready = 1'b0; up_valid = 1'b1; up_data = 64'h1;
      tick();
      up_data = 64'h2;
      tick();
      up_valid = 1'b0;
      settle();
      chk("bp_occ",      64'(occupancy), 64'd2);
      chk("bp_up_ready", 64'(up_ready),  64'd0);
      chk("bp_dn_data0", dn_data,        64'h1);
      tick();
      dn_ready = 1'b1;
      settle();
      chk("bp_dn_valid", 64'(dn_valid), 64'd1);
      chk("bp_first",    dn_data,       64'h1);
      tick();
      settle();
      chk("bp_second",   dn_data,        64'h2);
      chk("bp_occ_one",  64'(occupancy), 64'd1);
      tick();
      settle();
      chk("bp_drained",  64'(occupancy), 64'd0);

      // streaming words 0..99
      takes = 0; order_err = 0; occ_err = 0; next_exp = 64'd0;
      for (int i = 0; i <= 100; i++) begin
         up_valid = (i < 100);
         up_data  = 64'(i);
         dn_ready = 1'b1;
         settle();
         if (dn_valid && dn_ready) begin
            if (dn_data !== next_exp) order_err++;
            next_exp = next_exp + 64'd1;
            takes++;
         end
         if (i >= 1 && occupancy !== 2'd1) occ_err++;
         tick();
      end
      up_valid = 1'b0;
      settle();
      chk("stream_takes",     64'(takes),     64'd100);
      chk("stream_order_err", 64'(order_err), 64'd0);
      chk("stream_occ_err",   64'(occ_err),   64'd0);
      chk("stream_end_occ",   64'(occupancy), 64'd0);

      // flush while full
      tick();
      dn_ready = 1'b0; up_valid = 1'b1; up_data = 64'h3;
      tick();
      up_data = 64'h4;
      tick();
      settle();
      chk("fl_occ_full", 64'(occupancy), 64'd2);
      up_data = 64'h5; flush = 1'b1;
      settle();
      chk("fl_up_ready", 64'(up_ready), 64'd0);
      chk("fl_dn_valid", 64'(dn_valid), 64'd0);
      tick();
      flush = 1'b0; up_valid = 1'b0;
      settle();
      chk("fl_occ_empty", 64'(occupancy), 64'd0);
      chk("fl_dn_valid_after", 64'(dn_valid), 64'd0);

      // stall in ONE for 5 cycles
      up_valid = 1'b1; up_data = 64'h7;
      tick();
      up_valid = 1'b1; up_data = 64'h8; dn_ready = 1'b1; stall = 1'b1;
      dv_err = 0;
      for (int i = 0; i < 5; i++) begin
         settle();
         if (dn_valid !== 1'b0 || up_ready !== 1'b0) dv_err++;
         tick();
      end
      stall = 1'b0; up_valid = 1'b0;
      settle();
      chk("st_dv_err", 64'(dv_err),    64'd0);
      chk("st_main",   dn_data,        64'h7);
      chk("st_occ",    64'(occupancy), 64'd1);
`ifdef PIPELINE_BARRIER_STATS_EN
      chk("st_stall_cnt", 64'(stall_cnt), 64'd5);
      chk("st_flush_cnt", 64'(flush_cnt), 64'd1);
`endif
      tick();
      settle();
      chk("st_drained", 64'(occupancy), 64'd0);

      // reset mid-burst at occupancy 2
      dn_ready = 1'b0; up_valid = 1'b1; up_data = 64'h9;
      tick();
      up_data = 64'hA;
      tick();
      up_data = 64'hB;
      settle();
      chk("mr_occ_full", 64'(occupancy), 64'd2);
      rst = 1'b0;
      settle();
      chk("mr_occ",      64'(occupancy), 64'd0);
      chk("mr_dn_valid", 64'(dn_valid),  64'd0);
      chk("mr_up_ready", 64'(up_ready),  64'd0);
      chk("mr_dn_data",  dn_data,        64'd0);
      tick();
      @(negedge clk);
      rst = 1'b1; up_data = 64'h20; dn_ready = 1'b1;
      tick();
      settle();
      chk("mr_up_ready_back", 64'(up_ready),  64'd1);
      chk("mr_occ_back",      64'(occupancy), 64'd0);
      tick();
      up_valid = 1'b0;
      settle();
      chk("mr_resume_valid", 64'(dn_valid), 64'd1);
      chk("mr_resume_data",  dn_data,       64'h20);
      tick();
      settle();
      chk("mr_resume_empty", 64'(occupancy), 64'd0);
`ifdef PIPELINE_BARRIER_STATS_EN
      chk("mr_xfer_cnt", 64'(xfer_cnt), 64'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
